// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds and occupancy count
//
// Purpose: buffers words between a producer and a consumer in one clock domain.
//   Depth may be any integer >= 2. Almost-full/almost-empty thresholds are run-time
//   inputs. Occupancy is exported. Accept/reject events are reported as registered
//   single-cycle pulses.
// Configuration: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads. Leave it
//   undefined for registered reads, where data_out updates on the read edge.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   clear            synchronous flush (pointers, count, outputs to zero)
//   data_in          write data, stored when write_enable && !full
//   write_enable     write request
//   read_enable      read request (pop of the displayed word in FWFT mode)
//   af_thresh        almost_full when count >= af_thresh
//   ae_thresh        almost_empty when count <= ae_thresh
//   data_out         read data
//   data_valid       data_out holds a newly read word (FWFT: a word is displayed)
//   count            occupancy 0..MEM_DEPTH
//   full, empty      occupancy at MEM_DEPTH / zero
//   almost_full      occupancy at or above af_thresh
//   almost_empty     occupancy at or below ae_thresh
//   write_ack        previous-cycle write accepted
//   overflow         previous-cycle write rejected
//   underflow        previous-cycle read rejected
module sync_fifo_prog #(
  parameter int  DATA_WIDTH = 16,
  parameter int  MEM_DEPTH  = 16,
  localparam int CNT_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [CNT_WIDTH-1:0]  af_thresh,
  input  logic [CNT_WIDTH-1:0]  ae_thresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  write_ack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_WIDTH = $clog2(MEM_DEPTH);

  // Storage is deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [PTR_WIDTH-1:0] write_ptr_q, write_ptr_d;
  logic [PTR_WIDTH-1:0] read_ptr_q, read_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 write_ack_q, write_ack_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
`ifndef SYNC_FIFO_FWFT_EN
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
`endif

  logic wr_accept;
  logic rd_accept;
  logic mem_we;

  // The depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flags decode from the registered count only, so they are glitch-free
  // with respect to the request inputs.
  assign full         = (count_q == CNT_WIDTH'(MEM_DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (af_thresh == '0) || (count_q >= af_thresh);
  assign almost_empty = (ae_thresh >= CNT_WIDTH'(MEM_DEPTH)) || (count_q <= ae_thresh);

  assign wr_accept = write_enable && !full;
  assign rd_accept = read_enable && !empty;

  always_comb begin
    write_ptr_d = write_ptr_q;
    read_ptr_d  = read_ptr_q;
    count_d     = count_q;
    write_ack_d = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
`endif
    if (clear) begin
      write_ptr_d = '0;
      read_ptr_d  = '0;
      count_d     = '0;
`ifndef SYNC_FIFO_FWFT_EN
      data_out_d  = '0;
`endif
    end else begin
      mem_we      = wr_accept;
      write_ack_d = wr_accept;
      overflow_d  = write_enable && full;
      underflow_d = read_enable && empty;
      if (wr_accept) write_ptr_d = ptr_inc(write_ptr_q);
      if (rd_accept) read_ptr_d = ptr_inc(read_ptr_q);
      // A simultaneous accept on both sides leaves the count unchanged.
      if (wr_accept && !rd_accept) begin
        count_d = count_q + 1'b1;
      end else if (rd_accept && !wr_accept) begin
        count_d = count_q - 1'b1;
      end
`ifndef SYNC_FIFO_FWFT_EN
      if (rd_accept) begin
        data_out_d   = mem[read_ptr_q];
        data_valid_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_ptr_q <= '0;
      read_ptr_q  <= '0;
      count_q     <= '0;
      write_ack_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
`endif
    end else begin
      write_ptr_q <= write_ptr_d;
      read_ptr_q  <= read_ptr_d;
      count_q     <= count_d;
      write_ack_q <= write_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifndef SYNC_FIFO_FWFT_EN
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[write_ptr_q] <= data_in;
  end

  assign count     = count_q;
  assign write_ack = write_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`ifdef SYNC_FIFO_FWFT_EN
  // The head word is shown as soon as it is stored; read_enable pops it.
  assign data_out   = mem[read_ptr_q];
  assign data_valid = !empty;
`else
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

endmodule
